// File: rtl/uart_tx_arb.sv
// uart_tx_arb: round-robin sharing of one byte-wide UART transmitter among NUM_REQ word requesters.
module uart_tx_arb #(
  parameter int NUM_REQ    = 3,
  parameter int GAP_CYCLES = 0,
  parameter int TIMEOUT    = 32768
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NUM_REQ-1:0]     req,
  input  logic [NUM_REQ-1:0]     req_two,
  input  logic [16*NUM_REQ-1:0]  req_data,
  output logic [NUM_REQ-1:0]     ack,
  output logic                   err,
  output logic                   busy,
  output logic [2:0]             grant_id,
  output logic                   trmt,
  output logic [7:0]             tx_data,
  input  logic                   tx_done
);
  localparam int CW = $clog2(TIMEOUT);
  typedef enum logic [2:0] {IDLE, SEND_HI, WAIT_HI, SEND_LO, WAIT_LO, DONE, GAP} state_t;
  state_t state, state_n;
  logic [2:0] last_id;
  logic [15:0] data, sel_word, word;
  logic [CW-1:0] wcnt;
  logic [7:0] gcnt;
  logic abort, tx_done_q, rise, hit, any, sel_two, in_wait;
  int win;
  // scan descending so the nearest index after last_id is the final assignment
  always_comb begin
    win = 0;
    for (int i = NUM_REQ; i > 0; i--)
      if (|(req & (NUM_REQ'(1) << ((int'(last_id) + i) % NUM_REQ))))
        win = (int'(last_id) + i) % NUM_REQ;
  end
  always_comb begin
    any      = |req;
    sel_two  = |(req_two & (NUM_REQ'(1) << win));
    sel_word = 16'(req_data >> (16 * win));
    word     = state == IDLE ? sel_word : data;
    rise     = tx_done & ~tx_done_q;
    hit      = wcnt == CW'(TIMEOUT - 1);
    in_wait  = state == WAIT_HI || state == WAIT_LO;
    trmt     = state == SEND_HI || state == SEND_LO;
    busy     = state != IDLE;
    err      = state == DONE && abort;
    ack      = state == DONE ? NUM_REQ'(1) << grant_id : '0;
    state_n  = state;
    case (state)
      IDLE:    if (any) state_n = sel_two ? SEND_HI : SEND_LO;
      SEND_HI: state_n = WAIT_HI;
      SEND_LO: state_n = WAIT_LO;
      WAIT_HI: state_n = rise ? SEND_LO : hit ? DONE : WAIT_HI;
      WAIT_LO: if (rise || hit) state_n = DONE;
      DONE:    state_n = GAP_CYCLES > 0 ? GAP : IDLE;
      GAP:     if (gcnt == 8'(GAP_CYCLES - 1)) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      last_id   <= 3'(NUM_REQ - 1);
      grant_id  <= '0;
      data      <= '0;
      tx_data   <= '0;
      wcnt      <= '0;
      gcnt      <= '0;
      abort     <= 1'b0;
      tx_done_q <= 1'b0;
    end else begin
      state     <= state_n;
      tx_done_q <= tx_done;
      wcnt      <= in_wait ? wcnt + 1'b1 : '0;
      gcnt      <= state == GAP ? gcnt + 1'b1 : '0;
      if (state == IDLE && any) begin
        data     <= sel_word;
        grant_id <= 3'(win);
        last_id  <= 3'(win);
      end
      if (state_n == SEND_HI) tx_data <= word[15:8];
      if (state_n == SEND_LO) tx_data <= word[7:0];
      // a byte completing in the final watchdog cycle is not an abort
      if (state == DONE) abort <= 1'b0;
      else if (in_wait && hit && !rise) abort <= 1'b1;
    end
  end
endmodule

// File: tb/tb_uart_tx_arb.sv
// tb_uart_tx_arb: scoreboard bench; stimulus queues expected trmt/ack events, a monitor checks them.
module tb_uart_tx_arb;
  localparam int N = 3;
  logic clk = 1'b0, rst_n = 1'b0, tx_done = 1'b0;
  logic [N-1:0] req = '0, req_two = '0, ack;
  logic [16*N-1:0] req_data = '0;
  logic err, busy, trmt;
  logic [2:0] grant_id;
  logic [7:0] tx_data, gv;
  int checks = 0, errors = 0, dly = 8, mcnt = 0, cyc = 0, last_ev = 0, n, seen;
  bit hang = 1'b0, stale = 1'b0, is_a;
  typedef struct {bit is_ack; logic [7:0] val; logic e; int gap;} ev_t;
  ev_t q[$];
  ev_t ev;

  uart_tx_arb #(.NUM_REQ(N), .GAP_CYCLES(5), .TIMEOUT(16)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .req_two(req_two), .req_data(req_data),
    .ack(ack), .err(err), .busy(busy), .grant_id(grant_id), .trmt(trmt),
    .tx_data(tx_data), .tx_done(tx_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h", name, got, exp);
    end
  endtask

  task automatic push(input bit a, input logic [7:0] v, input logic e, input int g);
    q.push_back('{a, v, e, g});
  endtask

  task automatic tick(input int k);
    repeat (k) @(negedge clk);
  endtask

  task automatic wait_ack(input int id);
    int w = 0;
    do begin
      @(negedge clk);
      w++;
    end while (!ack[id] && w < 300);
    chk($sformatf("ack%0d_seen", id), 32'(ack[id]), 1);
  endtask

  // transmitter model: clears tx_done on trmt (late when stale), raises it dly cycles later
  initial forever begin
    @(posedge clk);
    #1;
    if (!rst_n) mcnt = 0;
    else begin
      if (mcnt > 0) begin
        mcnt--;
        if (stale && mcnt == dly - 3) tx_done = 1'b0;
        if (mcnt == 0 && !hang) tx_done = 1'b1;
      end
      if (trmt) begin
        mcnt = dly;
        if (!stale) tx_done = 1'b0;
      end
    end
  end

  initial forever begin
    @(negedge clk);
    cyc++;
    if (trmt || |ack) begin
      is_a = |ack;
      gv = is_a ? 8'(ack) : tx_data;
      checks++;
      if (q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_event ack=%b tx_data=%h cycle=%0d", ack, tx_data, cyc);
      end else begin
        ev = q.pop_front();
        if (ev.is_ack != is_a || ev.val !== gv || (is_a && err !== ev.e) ||
            (ev.gap >= 0 && cyc - last_ev != ev.gap)) begin
          errors++;
          $display("FAIL %s_event got val=%h err=%b gap=%0d want ack=%0d val=%h err=%b gap=%0d",
                   is_a ? "ack" : "trmt", gv, err, cyc - last_ev, ev.is_ack, ev.val, ev.e, ev.gap);
        end
      end
      last_ev = cyc;
    end
  end

  initial begin
    #100000;
    $display("FAIL global_timeout");
    $fatal(1);
  end

  initial begin
    tick(3);
    chk("rst_trmt", 32'(trmt), 0);
    chk("rst_ack", 32'(ack), 0);
    chk("rst_err", 32'(err), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_grant", 32'(grant_id), 0);
    chk("rst_tx_data", 32'(tx_data), 0);
    rst_n = 1'b1;
    tick(2);
    // round robin, all requesting
    req_data = {16'h0032, 16'h0021, 16'h0010};
    for (int k = 0; k < 6; k++) begin
      push(1'b0, 8'h10 + 8'(17 * (k % 3)), 1'b0, k == 0 ? -1 : 7);
      push(1'b1, 8'(1 << (k % 3)), 1'b0, 9);
    end
    req = 3'b111;
    tick(1);
    chk("rr_latency", 32'(trmt), 1);
    chk("rr_first_grant", 32'(grant_id), 0);
    for (int k = 0; k < 6; k++) begin
      wait_ack(k % 3);
      chk("rr_grant", 32'(grant_id), k % 3);
      req[k % 3] = 1'b0;
      tick(2);
      if (k < 3) req[k % 3] = 1'b1;
    end
    // single one-byte
    tick(8);
    req_data[15:0] = 16'h12C3;
    push(1'b0, 8'hC3, 1'b0, -1);
    push(1'b1, 8'h01, 1'b0, 9);
    req[0] = 1'b1;
    tick(1);
    chk("one_latency", 32'(trmt), 1);
    chk("one_tx_data", 32'(tx_data), 32'hC3);
    wait_ack(0);
    req[0] = 1'b0;
    chk("one_err", 32'(err), 0);
    // single two-byte
    tick(8);
    req_data[31:16] = 16'hA55A;
    req_two[1] = 1'b1;
    push(1'b0, 8'hA5, 1'b0, -1);
    push(1'b0, 8'h5A, 1'b0, 9);
    push(1'b1, 8'h02, 1'b0, 9);
    req[1] = 1'b1;
    tick(1);
    chk("two_latency", 32'(trmt), 1);
    wait_ack(1);
    req[1] = 1'b0;
    // watchdog abort, then normal service
    tick(8);
    hang = 1'b1;
    req_data[47:32] = 16'h00EE;
    push(1'b0, 8'hEE, 1'b0, -1);
    push(1'b1, 8'h04, 1'b1, 17);
    req[2] = 1'b1;
    wait_ack(2);
    req[2] = 1'b0;
    chk("wd_err", 32'(err), 1);
    hang = 1'b0;
    tick(6);
    chk("wd_idle", 32'(busy), 0);
    req_data[15:0] = 16'h0077;
    push(1'b0, 8'h77, 1'b0, -1);
    push(1'b1, 8'h01, 1'b0, 9);
    req[0] = 1'b1;
    wait_ack(0);
    req[0] = 1'b0;
    // byte completes in the very last watchdog cycle
    tick(8);
    dly = 16;
    req_two[1] = 1'b0;
    req_data[31:16] = 16'h0099;
    push(1'b0, 8'h99, 1'b0, -1);
    push(1'b1, 8'h02, 1'b0, 17);
    req[1] = 1'b1;
    wait_ack(1);
    req[1] = 1'b0;
    dly = 8;
    // stale tx_done level plus gap
    tick(8);
    stale = 1'b1;
    chk("stale_pre_done", 32'(tx_done), 1);
    req_two[1] = 1'b1;
    req_data[31:16] = 16'hBEEF;
    push(1'b0, 8'hBE, 1'b0, -1);
    push(1'b0, 8'hEF, 1'b0, 9);
    push(1'b1, 8'h02, 1'b0, 9);
    req[1] = 1'b1;
    wait_ack(1);
    req[1] = 1'b0;
    for (int k = 0; k < 5; k++) begin
      tick(1);
      chk("gap_busy", 32'(busy), 1);
    end
    tick(1);
    chk("gap_end", 32'(busy), 0);
    stale = 1'b0;
    // reset during WAIT_LO of requester 2 while requester 0 waits
    tick(2);
    req_data = {16'h3C7E, 16'h0000, 16'h0055};
    req_two = 3'b100;
    push(1'b0, 8'h3C, 1'b0, -1);
    push(1'b0, 8'h7E, 1'b0, 9);
    req = 3'b101;
    n = 0;
    seen = 0;
    while (seen < 2 && n < 100) begin
      @(negedge clk);
      n++;
      if (trmt) seen++;
    end
    chk("mid_two_trmt", 32'(seen), 2);
    tick(3);
    rst_n = 1'b0;
    push(1'b0, 8'h55, 1'b0, -1);
    push(1'b1, 8'h01, 1'b0, 9);
    push(1'b0, 8'h3C, 1'b0, 7);
    push(1'b0, 8'h7E, 1'b0, 9);
    push(1'b1, 8'h04, 1'b0, 9);
    tick(1);
    chk("mid_rst_trmt", 32'(trmt), 0);
    chk("mid_rst_busy", 32'(busy), 0);
    chk("mid_rst_ack", 32'(ack), 0);
    chk("mid_rst_grant", 32'(grant_id), 0);
    rst_n = 1'b1;
    wait_ack(0);
    chk("mid_first_grant", 32'(grant_id), 0);
    req[0] = 1'b0;
    wait_ack(2);
    req[2] = 1'b0;
    tick(10);
    chk("queue_empty", 32'(q.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
